// File: rtl/gravsim_regfile.sv
// gravsim_regfile: shared register file for the gravity simulator.
// A host slave port and six FSM ports access one array of state words.
// A control FSM (IDLE/START/BUSY/CLEAR) runs a step and clears the accelerations.
//
// Ports:
//   CLK, RESET_N                      clock, asynchronous active-low reset
//   AVL_CS/READ/WRITE/ADDR/WRITEDATA  host slave request
//   AVL_READDATA                      host read data, 1-cycle latency
//   FSM_re/FSM_we[1:0]                bit0 = group A (ports 1-3), bit1 = group B (ports 4-6)
//   ADDR1..6, DATA1..6                FSM word addresses and write data
//   DATA1in..DATA6in                  FSM read data, 1-cycle latency
//   FSM_DONE, clear_accs              step-done pulse, accumulator-clear request
//   FSM_START, BUSY, CLR_BUSY         control status
//   G, PLANET_NUM                     words 0 and 1
//   ERR                               sticky out-of-range access flag
//
// Optional feature: define REGFILE_BOUNDS_CHECK_EN for full 32-bit address
// checking and the sticky ERR flag. Without it only ADDRk[6:0] is decoded and
// ERR is tied low.
module gravsim_regfile #(
  parameter int unsigned NUM_WORDS = 114
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        AVL_CS,
  input  logic        AVL_READ,
  input  logic        AVL_WRITE,
  input  logic [6:0]  AVL_ADDR,
  input  logic [31:0] AVL_WRITEDATA,
  output logic [31:0] AVL_READDATA,
  input  logic [1:0]  FSM_re,
  input  logic [1:0]  FSM_we,
  input  logic [31:0] ADDR1,
  input  logic [31:0] ADDR2,
  input  logic [31:0] ADDR3,
  input  logic [31:0] ADDR4,
  input  logic [31:0] ADDR5,
  input  logic [31:0] ADDR6,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  input  logic [31:0] DATA3,
  input  logic [31:0] DATA4,
  input  logic [31:0] DATA5,
  input  logic [31:0] DATA6,
  output logic [31:0] DATA1in,
  output logic [31:0] DATA2in,
  output logic [31:0] DATA3in,
  output logic [31:0] DATA4in,
  output logic [31:0] DATA5in,
  output logic [31:0] DATA6in,
  input  logic        FSM_DONE,
  input  logic        clear_accs,
  output logic        FSM_START,
  output logic [31:0] G,
  output logic [31:0] PLANET_NUM,
  output logic        BUSY,
  output logic        CLR_BUSY,
  output logic        ERR
);

  localparam int unsigned AW        = 7;
  localparam int unsigned DW        = 32;
  localparam int unsigned DEPTH     = 2 ** AW;
  localparam int unsigned NPORT     = 6;
  localparam logic [AW-1:0] W_START = AW'(2);
  localparam logic [AW-1:0] W_DONE  = AW'(3);
  localparam logic [AW-1:0] ACC_LO  = AW'(84);
  localparam logic [AW-1:0] ACC_HI  = AW'(113);
  localparam logic [AW-1:0] ACC_Y0  = AW'(94);
  localparam logic [AW-1:0] ACC_Z0  = AW'(104);
  localparam logic [3:0]    CLR_LAST = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_CLEAR} state_t;

  state_t          r_state;
  state_t          r_ret_state;
  logic [3:0]      r_clr_cnt;
  logic            r_done_pend;
  logic [DW-1:0]   r_mem [DEPTH];
  logic [DW-1:0]   r_rd  [NPORT];

  logic [DW-1:0]   w_addr  [NPORT];
  logic [DW-1:0]   w_wdata [NPORT];
  logic [NPORT-1:0] w_ok;
  logic [NPORT-1:0] w_fsm_re;
  logic [NPORT-1:0] w_fsm_we;
  logic            w_host_ok;
  logic            w_host_we;
  logic            w_start_go;
  logic            w_done_go;
  logic            w_clr_go;
  logic [AW-1:0]   w_clr_x;
  logic [AW-1:0]   w_clr_y;
  logic [AW-1:0]   w_clr_z;

  // Address legality: full-width check when enabled, low 7 bits otherwise
  function automatic logic addr_ok(input logic [DW-1:0] a);
`ifdef REGFILE_BOUNDS_CHECK_EN
    return (a[DW-1:AW] == '0) && (32'(a[AW-1:0]) < NUM_WORDS);
`else
    return 32'(a[AW-1:0]) < NUM_WORDS;
`endif
  endfunction

  function automatic logic is_acc(input logic [AW-1:0] a);
    return (a >= ACC_LO) && (a <= ACC_HI);
  endfunction

  assign w_addr[0]  = ADDR1;
  assign w_addr[1]  = ADDR2;
  assign w_addr[2]  = ADDR3;
  assign w_addr[3]  = ADDR4;
  assign w_addr[4]  = ADDR5;
  assign w_addr[5]  = ADDR6;
  assign w_wdata[0] = DATA1;
  assign w_wdata[1] = DATA2;
  assign w_wdata[2] = DATA3;
  assign w_wdata[3] = DATA4;
  assign w_wdata[4] = DATA5;
  assign w_wdata[5] = DATA6;

  assign DATA1in    = r_rd[0];
  assign DATA2in    = r_rd[1];
  assign DATA3in    = r_rd[2];
  assign DATA4in    = r_rd[3];
  assign DATA5in    = r_rd[4];
  assign DATA6in    = r_rd[5];
  assign G          = r_mem[0];
  assign PLANET_NUM = r_mem[1];

  // Per-port enables; ACC writes are locked out for the whole clear sequence
  always_comb begin
    w_ok     = '0;
    w_fsm_re = '0;
    w_fsm_we = '0;
    for (int k = 0; k < int'(NPORT); k++) begin
      w_ok[k]     = addr_ok(w_addr[k]);
      w_fsm_re[k] = FSM_re[k / 3];
      w_fsm_we[k] = FSM_we[k / 3] && w_ok[k] &&
                    !((r_state == S_CLEAR) && is_acc(w_addr[k][AW-1:0]));
    end
  end

  // Host writes: only the DONE word is writable while a step or clear runs
  assign w_host_ok = addr_ok({25'd0, AVL_ADDR});
  assign w_host_we = AVL_CS && AVL_WRITE && w_host_ok &&
                     ((!BUSY && !CLR_BUSY) || (AVL_ADDR == W_DONE)) &&
                     !((r_state == S_CLEAR) && is_acc(AVL_ADDR));

  // Control events; an accumulator clear outranks a start or done in the same cycle
  assign w_clr_go   = clear_accs && ((r_state == S_IDLE) || (r_state == S_BUSY));
  assign w_start_go = (r_state == S_IDLE) && !clear_accs && AVL_CS && AVL_WRITE &&
                      (AVL_ADDR == W_START) && AVL_WRITEDATA[0];
  assign w_done_go  = ((r_state == S_BUSY) && FSM_DONE && !clear_accs) ||
                      ((r_state == S_CLEAR) && (r_clr_cnt == CLR_LAST) &&
                       (r_ret_state == S_BUSY) && (r_done_pend || FSM_DONE));

  // One planet's ACC_X/Y/Z per clear cycle
  assign w_clr_x = ACC_LO + AW'(r_clr_cnt);
  assign w_clr_y = ACC_Y0 + AW'(r_clr_cnt);
  assign w_clr_z = ACC_Z0 + AW'(r_clr_cnt);

  // Control FSM with registered status outputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_ret_state <= S_IDLE;
      r_clr_cnt   <= '0;
      r_done_pend <= 1'b0;
      FSM_START   <= 1'b0;
      BUSY        <= 1'b0;
      CLR_BUSY    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_clr_go) begin
            r_ret_state <= S_IDLE;
            r_state     <= S_CLEAR;
            r_clr_cnt   <= '0;
            r_done_pend <= 1'b0;
            CLR_BUSY    <= 1'b1;
          end else if (w_start_go) begin
            r_state   <= S_START;
            FSM_START <= 1'b1;
            BUSY      <= 1'b1;
          end
        end
        S_START: begin
          r_state   <= S_BUSY;
          FSM_START <= 1'b0;
        end
        S_BUSY: begin
          if (w_clr_go) begin
            r_ret_state <= S_BUSY;
            r_state     <= S_CLEAR;
            r_clr_cnt   <= '0;
            r_done_pend <= FSM_DONE;
            CLR_BUSY    <= 1'b1;
            BUSY        <= 1'b0;
          end else if (FSM_DONE) begin
            r_state <= S_IDLE;
            BUSY    <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (FSM_DONE && (r_ret_state == S_BUSY)) begin
            r_done_pend <= 1'b1;
          end
          if (r_clr_cnt == CLR_LAST) begin
            r_clr_cnt   <= '0;
            r_done_pend <= 1'b0;
            CLR_BUSY    <= 1'b0;
            if (w_done_go) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= r_ret_state;
              BUSY    <= (r_ret_state == S_BUSY);
            end
          end else begin
            r_clr_cnt <= r_clr_cnt + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Word array: host, then group A, then group B, then clear, then control (last wins)
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_host_we) begin
        r_mem[AVL_ADDR] <= AVL_WRITEDATA;
      end
      for (int k = 0; k < int'(NPORT); k++) begin
        if (w_fsm_we[k]) begin
          r_mem[w_addr[k][AW-1:0]] <= w_wdata[k];
        end
      end
      if (r_state == S_CLEAR) begin
        r_mem[w_clr_x] <= '0;
        r_mem[w_clr_y] <= '0;
        r_mem[w_clr_z] <= '0;
      end
      if (w_start_go) begin
        r_mem[W_DONE] <= '0;
      end
      if (w_done_go) begin
        r_mem[W_DONE]  <= 32'd1;
        r_mem[W_START] <= '0;
      end
    end
  end

  // Read ports: registered, pre-write data, zero for illegal addresses
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int k = 0; k < int'(NPORT); k++) begin
        r_rd[k] <= '0;
      end
      AVL_READDATA <= '0;
    end else begin
      for (int k = 0; k < int'(NPORT); k++) begin
        if (w_fsm_re[k]) begin
          r_rd[k] <= w_ok[k] ? r_mem[w_addr[k][AW-1:0]] : '0;
        end
      end
      if (AVL_CS && AVL_READ) begin
        AVL_READDATA <= w_host_ok ? r_mem[AVL_ADDR] : '0;
      end
    end
  end

`ifdef REGFILE_BOUNDS_CHECK_EN
  logic w_err_evt;

  assign w_err_evt = (AVL_CS && (AVL_READ || AVL_WRITE) && !w_host_ok) ||
                     (|((w_fsm_re | w_fsm_acc_we()) & ~w_ok));

  function automatic logic [NPORT-1:0] w_fsm_acc_we();
    logic [NPORT-1:0] v;
    for (int k = 0; k < int'(NPORT); k++) begin
      v[k] = FSM_we[k / 3];
    end
    return v;
  endfunction

  // Sticky until reset
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ERR <= 1'b0;
    end else if (w_err_evt) begin
      ERR <= 1'b1;
    end
  end
`else
  logic w_unused_hi;

  assign w_unused_hi = ^{ADDR1[DW-1:AW], ADDR2[DW-1:AW], ADDR3[DW-1:AW],
                         ADDR4[DW-1:AW], ADDR5[DW-1:AW], ADDR6[DW-1:AW]};
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_gravsim_regfile.sv
// Directed self-checking bench for gravsim_regfile.
module tb_gravsim_regfile;

  logic        CLK;
  logic        RESET_N;
  logic        AVL_CS, AVL_READ, AVL_WRITE;
  logic [6:0]  AVL_ADDR;
  logic [31:0] AVL_WRITEDATA, AVL_READDATA;
  logic [1:0]  FSM_re, FSM_we;
  logic [31:0] ADDR1, ADDR2, ADDR3, ADDR4, ADDR5, ADDR6;
  logic [31:0] DATA1, DATA2, DATA3, DATA4, DATA5, DATA6;
  logic [31:0] DATA1in, DATA2in, DATA3in, DATA4in, DATA5in, DATA6in;
  logic        FSM_DONE, clear_accs;
  logic        FSM_START, BUSY, CLR_BUSY, ERR;
  logic [31:0] G, PLANET_NUM;

  int n_tests;
  int n_fail;

  gravsim_regfile dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
    .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
    .FSM_re(FSM_re), .FSM_we(FSM_we),
    .ADDR1(ADDR1), .ADDR2(ADDR2), .ADDR3(ADDR3), .ADDR4(ADDR4), .ADDR5(ADDR5), .ADDR6(ADDR6),
    .DATA1(DATA1), .DATA2(DATA2), .DATA3(DATA3), .DATA4(DATA4), .DATA5(DATA5), .DATA6(DATA6),
    .DATA1in(DATA1in), .DATA2in(DATA2in), .DATA3in(DATA3in),
    .DATA4in(DATA4in), .DATA5in(DATA5in), .DATA6in(DATA6in),
    .FSM_DONE(FSM_DONE), .clear_accs(clear_accs),
    .FSM_START(FSM_START), .G(G), .PLANET_NUM(PLANET_NUM),
    .BUSY(BUSY), .CLR_BUSY(CLR_BUSY), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic host_wr(input logic [6:0] a, input logic [31:0] d);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_WRITEDATA = d;
    tick();
    AVL_CS = 1'b0; AVL_WRITE = 1'b0;
  endtask

  task automatic host_rd(input logic [6:0] a, output logic [31:0] d);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
    tick();
    d = AVL_READDATA;
    AVL_CS = 1'b0; AVL_READ = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    AVL_CS = 0; AVL_READ = 0; AVL_WRITE = 0; AVL_ADDR = '0; AVL_WRITEDATA = '0;
    FSM_re = '0; FSM_we = '0; FSM_DONE = 0; clear_accs = 0;
    ADDR1 = '0; ADDR2 = '0; ADDR3 = '0; ADDR4 = '0; ADDR5 = '0; ADDR6 = '0;
    DATA1 = '0; DATA2 = '0; DATA3 = '0; DATA4 = '0; DATA5 = '0; DATA6 = '0;
    #12;
    n_tests++;
    if ({FSM_START, BUSY, CLR_BUSY, ERR} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags got=%b exp=0000", {FSM_START, BUSY, CLR_BUSY, ERR});
    end
    n_tests++;
    if (G !== 32'd0 || PLANET_NUM !== 32'd0 || AVL_READDATA !== 32'd0 || DATA1in !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data got G=%h PN=%h RD=%h D1=%h exp all 0", G, PLANET_NUM, AVL_READDATA, DATA1in);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_g();
    host_wr(7'd0, 32'h4080_0000);
    host_wr(7'd1, 32'd4);
    n_tests++;
    if (G !== 32'h4080_0000) begin
      n_fail++;
      $display("FAIL g_word got=%h exp=40800000", G);
    end
    n_tests++;
    if (PLANET_NUM !== 32'd4) begin
      n_fail++;
      $display("FAIL planet_num got=%h exp=4", PLANET_NUM);
    end
  endtask

  task automatic test_start_done();
    logic [31:0] d;
    host_wr(7'd3, 32'hAA);
    host_wr(7'd2, 32'd1);
    n_tests++;
    if ({FSM_START, BUSY} !== 2'b11) begin
      n_fail++;
      $display("FAIL start_pulse got={START,BUSY}=%b exp=11", {FSM_START, BUSY});
    end
    tick();
    n_tests++;
    if ({FSM_START, BUSY} !== 2'b01) begin
      n_fail++;
      $display("FAIL start_one_cycle got={START,BUSY}=%b exp=01", {FSM_START, BUSY});
    end
    host_rd(7'd3, d);
    n_tests++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL done_cleared got=%h exp=0", d);
    end
    FSM_DONE = 1'b1;
    tick();
    FSM_DONE = 1'b0;
    n_tests++;
    if (BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_after_done got=%b exp=0", BUSY);
    end
    host_rd(7'd3, d);
    n_tests++;
    if (d !== 32'd1) begin
      n_fail++;
      $display("FAIL done_word got=%h exp=1", d);
    end
    host_rd(7'd2, d);
    n_tests++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL start_word got=%h exp=0", d);
    end
  endtask

  task automatic test_fsm_rw();
    FSM_we = 2'b11; ADDR1 = 32'd24; DATA1 = 32'h3F80_0000; ADDR4 = 32'd25; DATA4 = 32'hBF80_0000;
    tick();
    FSM_we = 2'b00; FSM_re = 2'b11;
    tick();
    FSM_re = 2'b00;
    n_tests++;
    if (DATA1in !== 32'h3F80_0000 || DATA4in !== 32'hBF80_0000) begin
      n_fail++;
      $display("FAIL fsm_readback got=%h/%h exp=3f800000/bf800000", DATA1in, DATA4in);
    end
    // read of a word written on the same edge returns its old value
    FSM_we = 2'b01; ADDR1 = 32'd24; DATA1 = 32'h1234_5678;
    FSM_re = 2'b10; ADDR4 = 32'd24;
    tick();
    FSM_we = 2'b00; FSM_re = 2'b00;
    n_tests++;
    if (DATA4in !== 32'h3F80_0000) begin
      n_fail++;
      $display("FAIL same_edge_old got=%h exp=3f800000", DATA4in);
    end
    // group B wins on equal addresses
    FSM_we = 2'b11; ADDR1 = 32'd30; DATA1 = 32'hA; ADDR4 = 32'd30; DATA4 = 32'hB;
    tick();
    FSM_we = 2'b00; FSM_re = 2'b01; ADDR1 = 32'd30;
    tick();
    FSM_re = 2'b00;
    n_tests++;
    if (DATA1in !== 32'hB) begin
      n_fail++;
      $display("FAIL group_b_wins got=%h exp=b", DATA1in);
    end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 7'd24; AVL_WRITEDATA = 32'd1;
    FSM_we = 2'b01; ADDR1 = 32'd24; DATA1 = 32'd2;
    tick();
    AVL_CS = 1'b0; AVL_WRITE = 1'b0; FSM_we = 2'b00;
    host_rd(7'd24, d);
    n_tests++;
    if (d !== 32'd2) begin
      n_fail++;
      $display("FAIL fsm_over_host got=%h exp=2", d);
    end
  endtask

  task automatic test_clear();
    logic [31:0] d;
    int n_hi;
    int nz;
    for (int i = 84; i <= 113; i += 2) begin
      FSM_we = 2'b11;
      ADDR1 = 32'(i);     DATA1 = 32'h1000 + 32'(i);
      ADDR4 = 32'(i + 1); DATA4 = 32'h1001 + 32'(i);
      tick();
    end
    FSM_we = 2'b00;
    host_wr(7'd4, 32'd7);
    host_wr(7'd2, 32'd1);
    tick();
    clear_accs = 1'b1;
    tick();
    clear_accs = 1'b0;
    n_hi = 0;
    if (CLR_BUSY) n_hi++;
    host_wr(7'd4, 32'd5);
    if (CLR_BUSY) n_hi++;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (!CLR_BUSY) break;
      n_hi++;
    end
    n_tests++;
    if (n_hi !== 10) begin
      n_fail++;
      $display("FAIL clr_busy_len got=%0d exp=10", n_hi);
    end
    n_tests++;
    if ({BUSY, CLR_BUSY} !== 2'b10) begin
      n_fail++;
      $display("FAIL clear_return_busy got={BUSY,CLR}=%b exp=10", {BUSY, CLR_BUSY});
    end
    nz = 0;
    for (int i = 84; i <= 113; i++) begin
      host_rd(7'(i), d);
      if (d !== 32'd0) nz++;
    end
    n_tests++;
    if (nz !== 0) begin
      n_fail++;
      $display("FAIL acc_zeroed got=%0d nonzero exp=0", nz);
    end
    host_rd(7'd4, d);
    n_tests++;
    if (d !== 32'd7) begin
      n_fail++;
      $display("FAIL host_drop_clear got=%h exp=7", d);
    end
    FSM_DONE = 1'b1;
    tick();
    FSM_DONE = 1'b0;
    n_tests++;
    if (BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_done_after_clear got=%b exp=0", BUSY);
    end
    // FSM_DONE arriving during the clear is applied on exit
    host_wr(7'd2, 32'd1);
    tick();
    clear_accs = 1'b1;
    tick();
    clear_accs = 1'b0;
    FSM_DONE = 1'b1;
    tick();
    FSM_DONE = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (!CLR_BUSY) break;
      tick();
    end
    n_tests++;
    if ({BUSY, CLR_BUSY} !== 2'b00) begin
      n_fail++;
      $display("FAIL latched_done got={BUSY,CLR}=%b exp=00", {BUSY, CLR_BUSY});
    end
    host_rd(7'd3, d);
    n_tests++;
    if (d !== 32'd1) begin
      n_fail++;
      $display("FAIL latched_done_word got=%h exp=1", d);
    end
  endtask

  task automatic test_bounds();
    logic [31:0] d;
    logic        exp_err;
    logic [31:0] exp_w5;
`ifdef REGFILE_BOUNDS_CHECK_EN
    exp_err = 1'b1;
    exp_w5  = 32'd0;
`else
    exp_err = 1'b0;
    exp_w5  = 32'h55;
`endif
    FSM_we = 2'b01; ADDR1 = 32'd120; DATA1 = 32'hDEAD;
    tick();
    FSM_we = 2'b00;
    n_tests++;
    if (ERR !== exp_err) begin
      n_fail++;
      $display("FAIL err_flag got=%b exp=%b", ERR, exp_err);
    end
    host_rd(7'd120, d);
    n_tests++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL host_rd_oob got=%h exp=0", d);
    end
    FSM_re = 2'b01; ADDR1 = 32'd120;
    tick();
    FSM_re = 2'b00;
    n_tests++;
    if (DATA1in !== 32'd0) begin
      n_fail++;
      $display("FAIL fsm_rd_oob got=%h exp=0", DATA1in);
    end
    FSM_we = 2'b01; ADDR1 = 32'h85; DATA1 = 32'h55;
    tick();
    FSM_we = 2'b00;
    host_rd(7'd5, d);
    n_tests++;
    if (d !== exp_w5) begin
      n_fail++;
      $display("FAIL high_addr_bits got=%h exp=%h", d, exp_w5);
    end
    n_tests++;
    if (ERR !== exp_err) begin
      n_fail++;
      $display("FAIL err_sticky got=%b exp=%b", ERR, exp_err);
    end
  endtask

  task automatic test_reset_mid();
    host_wr(7'd2, 32'd1);
    tick();
    clear_accs = 1'b1;
    tick();
    clear_accs = 1'b0;
    tick();
    #2;
    RESET_N = 1'b0;
    #1;
    n_tests++;
    if ({BUSY, CLR_BUSY, FSM_START, ERR} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_flags got=%b exp=0000", {BUSY, CLR_BUSY, FSM_START, ERR});
    end
    n_tests++;
    if (G !== 32'd0 || PLANET_NUM !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_words got G=%h PN=%h exp=0", G, PLANET_NUM);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({BUSY, CLR_BUSY} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_idle got=%b exp=00", {BUSY, CLR_BUSY});
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_g();
    test_start_done();
    test_fsm_rw();
    test_priority();
    test_clear();
    test_bounds();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gravsim_regfile.md
GRAVSIM_REGFILE -- requirements
Module: gravsim_regfile

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 114, words of simulation state (0..113).
REQ-002 SHALL have port CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RESET_N  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports AVL_CS, AVL_READ, AVL_WRITE  in  1 each  host slave strobes, qualified by AVL_CS.
REQ-005 SHALL have ports AVL_ADDR  in  7 (word address), AVL_WRITEDATA  in  32, AVL_READDATA  out  32.
REQ-006 SHALL have ports FSM_re, FSM_we  in  2  bit0 = group A (ADDR1-3), bit1 = group B (ADDR4-6).
REQ-007 SHALL have ports ADDR1..ADDR6  in  32  word addresses; only bits [6:0] are decoded.
REQ-008 SHALL have ports DATA1..DATA6  in  32  FSM write data.
REQ-009 SHALL have ports DATA1in..DATA6in  out  32  FSM read data.
REQ-010 SHALL have ports FSM_DONE, clear_accs  in  1  step-complete pulse and accumulator-clear request.
REQ-011 SHALL have ports FSM_START  out  1, G  out  32, PLANET_NUM  out  32, BUSY  out  1, CLR_BUSY  out  1, ERR  out  1.

Function
REQ-012 SHALL use this word map: 0 G, 1 PLANET_NUM, 2 START, 3 DONE; planet i (1..10): MASS 3+i, RAD 13+i, POS_X/Y/Z 23+i/33+i/43+i, VEL_X/Y/Z 53+i/63+i/73+i, ACC_X/Y/Z 83+i/93+i/103+i.
REQ-013 SHALL drive G and PLANET_NUM continuously from words 0 and 1.
REQ-014 SHALL return FSM reads with 1-cycle latency: DATAkin is loaded at the edge where the matching FSM_re bit is 1 and holds otherwise.
REQ-015 SHALL write DATAk to word ADDRk at the edge where the matching FSM_we bit is 1; group A then group B order, so B wins on equal addresses.
REQ-016 SHALL make a same-edge read of a word being written return the old value.
REQ-017 SHALL return host reads with 1-cycle latency on AVL_READDATA; host reads are allowed in every state.
REQ-018 SHALL give FSM writes priority over a host write to the same word in the same cycle; the host write is dropped.
REQ-019 SHALL use control FSM states IDLE, START, BUSY, CLEAR.
REQ-020 SHALL, in IDLE on a host write to word 2 with bit0=1: clear word 3, go to START.
REQ-021 SHALL assert FSM_START for exactly one cycle in START, then go to BUSY; BUSY=1 in START and BUSY.
REQ-022 SHALL, in BUSY on FSM_DONE=1: set word 3 to 1, clear word 2, go to IDLE.
REQ-023 SHALL drop host writes to any word other than 3 while BUSY=1 or CLR_BUSY=1.
REQ-024 SHALL ignore host START writes outside IDLE and FSM_DONE outside BUSY.
REQ-025 SHALL, on clear_accs=1 in IDLE or BUSY: save the return state, go to CLEAR, and zero ACC words 84..113, three per cycle, over 10 cycles using a 4-bit counter; CLR_BUSY=1 during CLEAR.
REQ-026 SHALL return to the saved state after the 10th clear cycle; clear_accs in CLEAR is ignored.
REQ-027 SHALL, in CLEAR, give the clear priority over FSM and host writes to ACC words; other FSM writes proceed.
REQ-028 SHALL latch FSM_DONE arriving in CLEAR and apply it on exit.

Reset
REQ-029 SHALL, on RESET_N=0: zero all words, DATA1in..DATA6in, AVL_READDATA, counter, FSM_START, BUSY, CLR_BUSY and ERR, and enter IDLE immediately.
REQ-030 SHALL abort a BUSY or CLEAR sequence on reset mid-operation, with no partial state surviving.

Configuration
REQ-031 SHALL, with REGFILE_BOUNDS_CHECK_EN defined: drop any FSM or host access to addresses >= NUM_WORDS or with nonzero ADDRk[31:7], return 0 for such reads, and set sticky ERR until reset.
REQ-032 SHALL, without REGFILE_BOUNDS_CHECK_EN: decode ADDRk[6:0] only, drop writes to words 114..127, return 0 for reads of them, and tie ERR to 0.

Verification
REQ-033 Reset, then host write word0=0x40800000, word1=4 -> G=0x40800000 and PLANET_NUM=4 next cycle.
REQ-034 Host write word2=1 in IDLE -> FSM_START high for exactly 1 cycle, word3=0, BUSY=1; FSM_DONE pulse -> word3=1, BUSY=0.
REQ-035 FSM_we=3 writing POS_X1 (24) and POS_X2 (25) = 0x3F800000 and 0xBF800000, then FSM_re=3 -> DATA1in/DATA4in equal those values one cycle later.
REQ-036 clear_accs pulse in BUSY with all ACC words nonzero -> CLR_BUSY for 10 cycles, words 84..113 = 0, state returns to BUSY; host write word4=5 during CLEAR is dropped.
REQ-037 Same-cycle host and FSM writes to word 24 (1 vs 2) -> word 24 = 2.
REQ-038 With REGFILE_BOUNDS_CHECK_EN, FSM write to ADDR1=120 -> no word changes, ERR=1 until reset; without the macro, ERR stays 0 and reads of word 120 return 0.
